// File: rtl/mdio_responder.sv
// Clause 22 MDIO responder: oversamples MDC/MDIO, drives register strobes.
// MDIO_PREAMBLE_SUPPRESSION_EN: accept ST after a single idle one.
module mdio_responder #(
   parameter logic [4:0] PHY_ADDR = 5'd1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mdc,
   input  logic        mdio_in,
   output logic        mdio_out,
   output logic        mdio_oe,
   output logic [4:0]  reg_addr,
   output logic [15:0] reg_wdata,
   output logic        reg_we,
   output logic        reg_re,
   input  logic [15:0] reg_rdata
);

`ifdef MDIO_PREAMBLE_SUPPRESSION_EN
   localparam logic [5:0] PRE_MIN = 6'd1;
`else
   localparam logic [5:0] PRE_MIN = 6'd32;
`endif
   localparam logic [5:0] PRE_MAX = 6'd32;
   localparam logic [1:0] OP_RD = 2'b10;
   localparam logic [1:0] OP_WR = 2'b01;

   typedef enum logic [3:0] {
      IDLE,
      START,
      OP,
      PHYAD,
      REGAD,
      TA,
      WDATA,
      RDATA,
      SKIP
   } state_t;

   state_t      state, state_n;
   logic [1:0]  mdc_sync, mdio_sync;
   logic        mdc_d;
   logic        mdc_rise, bit_in;
   logic [4:0]  bit_cnt, bit_cnt_n;
   logic [5:0]  pre_cnt, pre_cnt_n;
   logic [1:0]  op, op_n;
   logic [4:0]  phy, phy_n;
   logic [4:0]  regad, regad_n;
   logic [15:0] shreg, shreg_n;
   logic        out_n, oe_n, we_n, re_n;
   logic [4:0]  addr_n;
   logic [15:0] wdata_n;

   always_ff @(posedge clk) begin
      mdc_sync  <= {mdc_sync[0], mdc};
      mdio_sync <= {mdio_sync[0], mdio_in};
      mdc_d     <= mdc_sync[1];
   end

   assign mdc_rise = mdc_sync[1] & ~mdc_d;
   assign bit_in   = mdio_sync[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         pre_cnt   <= '0;
         op        <= '0;
         phy       <= '0;
         regad     <= '0;
         shreg     <= '0;
         mdio_out  <= 1'b0;
         mdio_oe   <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_we    <= 1'b0;
         reg_re    <= 1'b0;
      end else begin
         state     <= state_n;
         bit_cnt   <= bit_cnt_n;
         pre_cnt   <= pre_cnt_n;
         op        <= op_n;
         phy       <= phy_n;
         regad     <= regad_n;
         shreg     <= shreg_n;
         mdio_out  <= out_n;
         mdio_oe   <= oe_n;
         reg_addr  <= addr_n;
         reg_wdata <= wdata_n;
         reg_we    <= we_n;
         reg_re    <= re_n;
      end
   end

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      pre_cnt_n = pre_cnt;
      op_n      = op;
      phy_n     = phy;
      regad_n   = regad;
      shreg_n   = shreg;
      out_n     = mdio_out;
      oe_n      = mdio_oe;
      addr_n    = reg_addr;
      wdata_n   = reg_wdata;
      we_n      = 1'b0;
      re_n      = 1'b0;
      if (mdc_rise) begin
         bit_cnt_n = bit_cnt + 5'd1;
         unique case (state)
            IDLE: begin
               bit_cnt_n = '0;
               if (bit_in) begin
                  if (pre_cnt != PRE_MAX) pre_cnt_n = pre_cnt + 6'd1;
               end else if (pre_cnt >= PRE_MIN) begin
                  pre_cnt_n = '0;
                  state_n   = START;
               end else begin
                  pre_cnt_n = '0;
               end
            end
            START: begin
               bit_cnt_n = '0;
               state_n   = bit_in ? OP : IDLE;
            end
            OP: begin
               op_n = {op[0], bit_in};
               if (bit_cnt == 5'd1) begin
                  bit_cnt_n = '0;
                  state_n   = PHYAD;
               end
            end
            PHYAD: begin
               phy_n = {phy[3:0], bit_in};
               if (bit_cnt == 5'd4) begin
                  bit_cnt_n = '0;
                  state_n   = REGAD;
               end
            end
            REGAD: begin
               regad_n = {regad[3:0], bit_in};
               if (bit_cnt == 5'd4) begin
                  bit_cnt_n = '0;
                  if (phy == PHY_ADDR && (op == OP_RD || op == OP_WR)) begin
                     addr_n  = regad_n;
                     re_n    = (op == OP_RD);
                     state_n = TA;
                  end else begin
                     state_n = SKIP;
                  end
               end
            end
            TA: begin
               if (bit_cnt == 5'd0) begin
                  if (op == OP_RD) begin
                     oe_n    = 1'b1;
                     out_n   = 1'b0;
                     shreg_n = reg_rdata;
                  end
               end else begin
                  bit_cnt_n = '0;
                  if (op == OP_RD) begin
                     out_n   = shreg[15];
                     shreg_n = {shreg[14:0], 1'b0};
                     state_n = RDATA;
                  end else begin
                     state_n = WDATA;
                  end
               end
            end
            RDATA: begin
               if (bit_cnt == 5'd15) begin
                  oe_n      = 1'b0;
                  out_n     = 1'b0;
                  bit_cnt_n = '0;
                  state_n   = IDLE;
               end else begin
                  out_n   = shreg[15];
                  shreg_n = {shreg[14:0], 1'b0};
               end
            end
            WDATA: begin
               shreg_n = {shreg[14:0], bit_in};
               if (bit_cnt == 5'd15) begin
                  wdata_n   = shreg_n;
                  we_n      = 1'b1;
                  bit_cnt_n = '0;
                  state_n   = IDLE;
               end
            end
            SKIP: begin
               // TA plus data must be swallowed so they never look like preamble
               if (bit_cnt == 5'd17) begin
                  bit_cnt_n = '0;
                  state_n   = IDLE;
               end
            end
            default: begin
               bit_cnt_n = '0;
               state_n   = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdio_responder.sv
// Scoreboard bench for mdio_responder: a station model drives MDC/MDIO,
// expectations are queued and a monitor compares DUT activity against them.
module tb_mdio_responder;

   localparam int K_WE    = 0;
   localparam int K_RE    = 1;
   localparam int K_RD    = 2;
   localparam int P_TA2   = 3;
   localparam int P_QUIET = 4;
   localparam int P_OE    = 5;
   localparam int P_OUT   = 6;
   localparam int P_ADDR  = 7;
   localparam int P_WDATA = 8;
   localparam int P_WE    = 9;
   localparam int P_RE    = 10;

   typedef struct {
      int          kind;
      logic [4:0]  addr;
      logic [15:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mdc = 1'b0;
   logic        st_oe = 1'b0;
   logic        st_val = 1'b1;
   logic        line;
   logic        mdio_out, mdio_oe, reg_we, reg_re;
   logic [4:0]  reg_addr;
   logic [15:0] reg_wdata, reg_rdata;
   logic [15:0] rf [32];

   exp_t        exp_q [$];
   int          checks = 0;
   int          failures = 0;
   int          oe_viol = 0;
   logic        quiet = 1'b0;
   logic        pr_stb = 1'b0;
   int          pr_kind = 0;
   logic [15:0] pr_val = 16'h0;
   logic        done = 1'b0;
   int          lo = 6;
   int          hi = 6;

   assign line = mdio_oe ? mdio_out : (st_oe ? st_val : 1'b1);

   mdio_responder #(.PHY_ADDR(5'd1)) dut (
      .clk       (clk),
      .reset     (reset),
      .mdc       (mdc),
      .mdio_in   (line),
      .mdio_out  (mdio_out),
      .mdio_oe   (mdio_oe),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_we    (reg_we),
      .reg_re    (reg_re),
      .reg_rdata (reg_rdata)
   );

   always #5 clk = ~clk;

   // register file model: read data appears only the cycle after reg_re
   always @(posedge clk) begin
      if (reset) begin
         rf[2]     <= 16'h1234;
         rf[7]     <= 16'h0000;
         reg_rdata <= 16'hDEAD;
      end else begin
         if (reg_we) rf[reg_addr] <= reg_wdata;
         if (reg_re) reg_rdata <= rf[reg_addr];
      end
   end

   function automatic string kname(input int k);
      case (k)
         K_WE:    return "reg_we";
         K_RE:    return "reg_re";
         K_RD:    return "read_word";
         P_TA2:   return "ta2_zero";
         P_QUIET: return "oe_quiet";
         P_OE:    return "mdio_oe";
         P_OUT:   return "rst_mdio_out";
         P_ADDR:  return "rst_reg_addr";
         P_WDATA: return "rst_reg_wdata";
         P_WE:    return "rst_reg_we";
         P_RE:    return "rst_reg_re";
         default: return "unknown";
      endcase
   endfunction

   task automatic cmp(input int k, input logic [4:0] a,
                      input logic [15:0] d);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL %s: unexpected event addr=%0d data=%h, required none",
                  kname(k), a, d);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.addr !== a || e.data !== d) begin
            failures++;
            $display("FAIL %s: got %s addr=%0d data=%h, required %s addr=%0d data=%h",
                     kname(e.kind), kname(k), a, d, kname(e.kind), e.addr, e.data);
         end
      end
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (quiet && mdio_oe) oe_viol++;
         if (reg_we && reg_re) begin
            checks++;
            failures++;
            $display("FAIL we_re_overlap: got we=1 re=1, required not both");
         end
         if (reg_we) cmp(K_WE, reg_addr, reg_wdata);
         if (reg_re) cmp(K_RE, reg_addr, 16'h0);
         if (pr_stb) cmp(pr_kind, 5'd0, pr_val);
         if (done) begin
            checks++;
            if (exp_q.size() != 0) begin
               failures++;
               $display("FAIL pending: got %0d outstanding, required 0",
                        exp_q.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got no end of run, required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic push(input int k, input logic [4:0] a,
                       input logic [15:0] d);
      exp_t e;
      e.kind = k;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic probe(input int k, input logic [15:0] expv,
                        input logic [15:0] act);
      push(k, 5'd0, expv);
      pr_kind = k;
      pr_val  = act;
      @(posedge clk);
      pr_stb = 1'b1;
      @(posedge clk);
      pr_stb = 1'b0;
   endtask

   task automatic send_bit(input logic v);
      st_oe  = 1'b1;
      st_val = v;
      repeat (lo) @(negedge clk);
      mdc = 1'b1;
      repeat (hi) @(negedge clk);
      mdc = 1'b0;
   endtask

   task automatic rel_bit(output logic s);
      st_oe = 1'b0;
      repeat (lo) @(negedge clk);
      s   = line;
      mdc = 1'b1;
      repeat (hi) @(negedge clk);
      mdc = 1'b0;
   endtask

   task automatic do_reset();
      logic v;
      probe(P_OE, 16'd1, {15'd0, mdio_oe});
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 v = mdio_oe;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      probe(P_OE, 16'd0, {15'd0, v});
   endtask

   task automatic frame(input int npre, input logic [1:0] op,
                        input logic [4:0] phy, input logic [4:0] ra,
                        input logic [15:0] wd, input logic rel,
                        input int abort_idx,
                        output logic [15:0] word, output logic ta2);
      logic        s;
      logic [13:0] hdr;
      hdr  = {2'b01, op, phy, ra};
      word = 16'h0;
      ta2  = 1'b1;
      for (int i = 0; i < npre; i++) send_bit(1'b1);
      for (int i = 13; i >= 0; i--) send_bit(hdr[i]);
      if (!rel) begin
         send_bit(1'b1);
         send_bit(1'b0);
         for (int i = 15; i >= 0; i--) send_bit(wd[i]);
      end else begin
         for (int i = 0; i < 18; i++) begin
            if (i == abort_idx) do_reset();
            rel_bit(s);
            if (i == 1) ta2 = s;
            if (i >= 2) word = {word[14:0], s};
         end
      end
   endtask

   task automatic read_ok(input int npre, input logic [4:0] ra,
                          input logic [15:0] expv);
      logic [15:0] w;
      logic        t;
      push(K_RE, ra, 16'h0);
      frame(npre, 2'b10, 5'd1, ra, 16'h0, 1'b1, -1, w, t);
      probe(K_RD, expv, w);
      probe(P_TA2, 16'h0, {15'd0, t});
   endtask

   task automatic quiet_frame(input int npre, input logic [1:0] op,
                              input logic [4:0] phy, input logic [4:0] ra,
                              input logic [15:0] wd, input logic rel);
      logic [15:0] w;
      logic        t;
      quiet = 1'b1;
      frame(npre, op, phy, ra, wd, rel, -1, w, t);
      probe(P_QUIET, 16'd0, 16'(oe_viol));
      quiet = 1'b0;
   endtask

   initial begin : stimulus
      logic [15:0] w;
      logic        t;
      repeat (4) @(negedge clk);
      probe(P_OUT, 16'd0, {15'd0, mdio_out});
      probe(P_OE, 16'd0, {15'd0, mdio_oe});
      probe(P_ADDR, 16'd0, {11'd0, reg_addr});
      probe(P_WDATA, 16'd0, reg_wdata);
      probe(P_WE, 16'd0, {15'd0, reg_we});
      probe(P_RE, 16'd0, {15'd0, reg_re});
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      push(K_WE, 5'd4, 16'hA5C3);
      quiet_frame(32, 2'b01, 5'd1, 5'd4, 16'hA5C3, 1'b0);

      read_ok(32, 5'd2, 16'h1234);

      quiet_frame(32, 2'b01, 5'd3, 5'd4, 16'h00FF, 1'b0);
      read_ok(32, 5'd2, 16'h1234);

      quiet_frame(32, 2'b11, 5'd1, 5'd2, 16'h0, 1'b1);

`ifdef MDIO_PREAMBLE_SUPPRESSION_EN
      read_ok(1, 5'd2, 16'h1234);
`else
      quiet_frame(31, 2'b10, 5'd1, 5'd2, 16'h0, 1'b1);
`endif

      push(K_RE, 5'd2, 16'h0);
      frame(32, 2'b10, 5'd1, 5'd2, 16'h0, 1'b1, 9, w, t);
      read_ok(32, 5'd2, 16'h1234);

      lo = 4;
      hi = 4;
      push(K_WE, 5'd7, 16'h5A5A);
      frame(32, 2'b01, 5'd1, 5'd7, 16'h5A5A, 1'b0, -1, w, t);
      read_ok(32, 5'd7, 16'h5A5A);

      repeat (20) @(posedge clk);
      done = 1'b1;
   end

endmodule
